snap_capture: RTL and testbench

- Parametrised multi-channel sample-capture buffer.
- Samples a CH-bit input bus at a programmable clock divisor and packs samples into WORD_W-bit words.
- Stores the words in an internal DEPTH-word RAM, either as a single-shot fill or as a circular buffer, with optional pattern trigger.
- Captured words are read back one word per request by the SPI command handler, which forwards them to the host.

---
 rtl/snap_capture.sv | 163 ++++++++++++++++
 tb/tb_snap_capture.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/snap_capture.sv
// snap_capture: divided-rate sampler that packs channel samples into words
// and stores them in a one-shot or circular RAM with optional pattern trigger.
module snap_capture #(
  parameter int CH     = 1,
  parameter int WORD_W = 16,
  parameter int DEPTH  = 256,
  parameter int ADDR_W = 8,
  parameter int DIV_W  = 8
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [CH-1:0]     din,
  input  logic [DIV_W-1:0]  div,
  input  logic              mode,
  input  logic              trig_en,
  input  logic [CH-1:0]     trig_mask,
  input  logic [CH-1:0]     trig_val,
  input  logic              arm,
  input  logic              stop,
  input  logic              rd_req,
  output logic [WORD_W-1:0] rd_data,
  output logic              rd_valid,
  output logic              busy,
  output logic              done,
  output logic              wrapped,
  output logic [ADDR_W:0]   word_count
);

  localparam int SPW  = WORD_W / CH;
  localparam int PK_W = (SPW > 1) ? $clog2(SPW) : 1;
  localparam logic [PK_W-1:0]   PK_LAST  = PK_W'(SPW - 1);
  localparam logic [ADDR_W:0]   CNT_FULL = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W-1:0] PTR_LAST = {ADDR_W{1'b1}};

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_CAP,
    S_DONE
  } state_t;

  state_t              st_q, st_d;
  logic [DIV_W-1:0]    div_q, div_d;
  logic [DIV_W-1:0]    cnt_q, cnt_d;
  logic [WORD_W-1:0]   word_q, word_d;
  logic [PK_W-1:0]     pk_q, pk_d;
  logic [ADDR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [ADDR_W:0]     wc_q, wc_d;
  logic                wrap_q, wrap_d;
  logic [WORD_W-1:0]   rd_data_q;
  logic                rd_valid_q;
  logic                we;
  logic                rd_en;
  logic                tick;
  logic                match;
  logic [WORD_W+CH-1:0] shifted;
  logic [WORD_W-1:0]   mem_q [DEPTH];

  assign tick    = (cnt_q == div_q);
  assign match   = ((din ^ trig_val) & trig_mask) == '0;
  assign shifted = {din, word_q};

  // Next-state: capture sequencing, packing, pointers and readout
  always_comb begin
    st_d     = st_q;
    div_d    = div_q;
    cnt_d    = cnt_q;
    word_d   = word_q;
    pk_d     = pk_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    wc_d     = wc_q;
    wrap_d   = wrap_q;
    we       = 1'b0;
    rd_en    = 1'b0;
    unique case (st_q)
      S_IDLE, S_DONE: begin
        rd_en = rd_req;
        if (rd_req) rd_ptr_d = rd_ptr_q + ADDR_W'(1);
        if (arm && !stop) begin
          st_d     = trig_en ? S_WAIT : S_CAP;
          div_d    = div;
          cnt_d    = '0;
          pk_d     = '0;
          wr_ptr_d = '0;
          rd_ptr_d = '0;
          wc_d     = '0;
          wrap_d   = 1'b0;
        end
      end
      S_WAIT, S_CAP: begin
        cnt_d = tick ? '0 : cnt_q + DIV_W'(1);
        if (stop) begin
          st_d     = S_DONE;
          rd_ptr_d = wrap_q ? wr_ptr_q : '0;
        end else if (tick && (st_q == S_CAP || match)) begin
          st_d   = S_CAP;
          word_d = shifted[WORD_W+CH-1:CH];
          if (pk_q == PK_LAST) begin
            pk_d     = '0;
            we       = 1'b1;
            wr_ptr_d = wr_ptr_q + ADDR_W'(1);
            if (wc_q != CNT_FULL) wc_d = wc_q + (ADDR_W+1)'(1);
            if (wr_ptr_q == PTR_LAST) begin
              if (mode) begin
                wrap_d = 1'b1;
              end else begin
                st_d     = S_DONE;
                rd_ptr_d = '0;
              end
            end
          end else begin
            pk_d = pk_q + PK_W'(1);
          end
        end
      end
      default: st_d = S_IDLE;
    endcase
  end

  // State and datapath registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      st_q       <= S_IDLE;
      div_q      <= '0;
      cnt_q      <= '0;
      word_q     <= '0;
      pk_q       <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      wc_q       <= '0;
      wrap_q     <= 1'b0;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      st_q       <= st_d;
      div_q      <= div_d;
      cnt_q      <= cnt_d;
      word_q     <= word_d;
      pk_q       <= pk_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      wc_q       <= wc_d;
      wrap_q     <= wrap_d;
      rd_valid_q <= rd_en;
      if (rd_en) rd_data_q <= mem_q[rd_ptr_q];
    end
  end

  // Capture RAM write port; contents survive reset
  always_ff @(posedge clk) begin
    if (we) mem_q[wr_ptr_q] <= word_d;
  end

  assign rd_data    = rd_data_q;
  assign rd_valid   = rd_valid_q;
  assign busy       = (st_q == S_WAIT) || (st_q == S_CAP);
  assign done       = (st_q == S_DONE);
  assign wrapped    = wrap_q;
  assign word_count = wc_q;

endmodule

// File: tb/tb_snap_capture.sv
// tb_snap_capture: directed/random checks of snap_capture against
// a word-list model built from the driven sample stream.
module tb_snap_capture;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset_n;

  logic [0:0]  din1;
  logic [7:0]  div1;
  logic        mode1, te1;
  logic [0:0]  tm1, tv1;
  logic        arm1, stop1, rq1;
  logic [15:0] rd1;
  logic        rv1, busy1, done1, wrap1;
  logic [8:0]  wc1;

  logic [3:0]  din4;
  logic [7:0]  div4;
  logic        mode4, te4;
  logic [3:0]  tm4, tv4;
  logic        arm4, stop4, rq4;
  logic [15:0] rd4;
  logic        rv4, busy4, done4, wrap4;
  logic [4:0]  wc4;

  snap_capture #(.CH(1), .WORD_W(16), .DEPTH(256), .ADDR_W(8), .DIV_W(8)) u_d1 (
    .clk(clk), .reset_n(reset_n), .din(din1), .div(div1), .mode(mode1),
    .trig_en(te1), .trig_mask(tm1), .trig_val(tv1), .arm(arm1),
    .stop(stop1), .rd_req(rq1), .rd_data(rd1), .rd_valid(rv1),
    .busy(busy1), .done(done1), .wrapped(wrap1), .word_count(wc1)
  );

  snap_capture #(.CH(4), .WORD_W(16), .DEPTH(16), .ADDR_W(4), .DIV_W(8)) u_d4 (
    .clk(clk), .reset_n(reset_n), .din(din4), .div(div4), .mode(mode4),
    .trig_en(te4), .trig_mask(tm4), .trig_val(tv4), .arm(arm4),
    .stop(stop4), .rd_req(rq4), .rd_data(rd4), .rd_valid(rv4),
    .busy(busy4), .done(done4), .wrapped(wrap4), .word_count(wc4)
  );

  int checks = 0;
  int errors = 0;

  logic [15:0] exp_w[$];
  logic [15:0] acc;
  int          nb;
  logic [3:0]  s4[$];

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic arm_d1(input logic [7:0] d, input logic m);
    div1 = d;
    mode1 = m;
    arm1 = 1'b1;
    @(negedge clk);
    arm1 = 1'b0;
    exp_w.delete();
    acc = '0;
    nb = 0;
  endtask

  // One sample per clock (div=0); model forms words LSB-first
  task automatic feed1(input int n, input bit pat);
    for (int k = 0; k < n; k++) begin
      logic b;
      if (pat && k < 16) b = (k == 0 || k == 15);
      else b = 1'($urandom_range(0, 1));
      din1 = b;
      acc = acc | (16'(b) << nb);
      nb++;
      if (nb == 16) begin
        exp_w.push_back(acc);
        acc = '0;
        nb = 0;
      end
      @(negedge clk);
    end
  endtask

  task automatic stop_d1();
    stop1 = 1'b1;
    @(negedge clk);
    stop1 = 1'b0;
  endtask

  initial begin
    int base;
    int st;
    int t;
    logic [15:0] e4;
    reset_n = 1'b0;
    din1 = '0; div1 = '0; mode1 = 0; te1 = 0; tm1 = '0; tv1 = '0;
    arm1 = 0; stop1 = 0; rq1 = 0;
    din4 = '0; div4 = '0; mode4 = 0; te4 = 0; tm4 = '0; tv4 = '0;
    arm4 = 0; stop4 = 0; rq4 = 0;
    acc = '0; nb = 0;

    #1;
    check("rst_busy", 32'(busy1), 0);
    check("rst_done", 32'(done1), 0);
    check("rst_wrap", 32'(wrap1), 0);
    check("rst_wc", 32'(wc1), 0);
    check("rst_rv", 32'(rv1), 0);
    check("rst_rdata", 32'(rd1), 0);
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);

    // arm and stop together from IDLE
    arm1 = 1'b1;
    stop1 = 1'b1;
    @(negedge clk);
    arm1 = 1'b0;
    stop1 = 1'b0;
    check("armstop_busy", 32'(busy1), 0);
    check("armstop_done", 32'(done1), 0);
    check("armstop_wc", 32'(wc1), 0);

    // single-shot full fill
    arm_d1(8'd0, 1'b0);
    check("ss_busy", 32'(busy1), 1);
    feed1(4096, 1'b1);
    check("ss_done", 32'(done1), 1);
    check("ss_busy_end", 32'(busy1), 0);
    check("ss_wc", 32'(wc1), 32'(exp_w.size()));
    check("ss_wrap", 32'(wrap1), 0);
    for (int i = 0; i < 256; i++) begin
      rq1 = 1'b1;
      @(negedge clk);
      check("ss_rv", 32'(rv1), 1);
      check("ss_rd", 32'(rd1), 32'(exp_w[i]));
      if (i == 0) check("ss_first", 32'(rd1), 32'h8001);
    end
    rq1 = 1'b0;
    @(negedge clk);
    check("ss_rv_end", 32'(rv1), 0);

    // divisor: first write 64 clocks after arm
    arm_d1(8'd3, 1'b0);
    din1 = 1'b1;
    for (int i = 0; i < 63; i++) @(negedge clk);
    check("div_wc63", 32'(wc1), 0);
    @(negedge clk);
    check("div_wc64", 32'(wc1), 1);
    stop_d1();
    rq1 = 1'b1;
    @(negedge clk);
    rq1 = 1'b0;
    check("div_word", 32'(rd1), 32'hFFFF);

    // partial word discard and rd_req ignored during capture
    arm_d1(8'd0, 1'b0);
    rq1 = 1'b1;
    feed1(1, 1'b0);
    rq1 = 1'b0;
    check("cap_rq_rv", 32'(rv1), 0);
    feed1(20, 1'b0);
    check("part_pre_wc", 32'(wc1), 1);
    stop_d1();
    check("part_done", 32'(done1), 1);
    check("part_wc", 32'(wc1), 32'(exp_w.size()));
    rq1 = 1'b1;
    @(negedge clk);
    rq1 = 1'b0;
    check("part_word", 32'(rd1), 32'(exp_w[0]));

    // circular: 300 words then stop
    arm_d1(8'd0, 1'b1);
    feed1(4800, 1'b0);
    stop_d1();
    base = (exp_w.size() > 256) ? exp_w.size() - 256 : 0;
    check("circ_done", 32'(done1), 1);
    check("circ_wrap", 32'(wrap1), 1);
    check("circ_wc", 32'(wc1), 256);
    rq1 = 1'b1;
    #1;
    check("circ_rv_pre", 32'(rv1), 0);
    @(negedge clk);
    rq1 = 1'b0;
    check("circ_rv", 32'(rv1), 1);
    check("circ_oldest", 32'(rd1), 32'(exp_w[base]));
    @(negedge clk);
    check("circ_rv_drop", 32'(rv1), 0);
    for (int i = 1; i < 4; i++) begin
      rq1 = 1'b1;
      @(negedge clk);
      check("circ_rd", 32'(rd1), 32'(exp_w[base + i]));
    end
    rq1 = 1'b0;

    // pattern trigger on the 4-channel instance
    te4 = 1'b1;
    tm4 = 4'hF;
    tv4 = 4'hA;
    st = int'($urandom_range(0, 15));
    arm4 = 1'b1;
    @(negedge clk);
    arm4 = 1'b0;
    s4.delete();
    for (int k = 0; k < 100; k++) begin
      din4 = 4'((st + k) % 16);
      s4.push_back(din4);
      if (k == 0) check("trig_busy", 32'(busy4), 1);
      @(negedge clk);
      if (wc4 != 0) break;
    end
    stop4 = 1'b1;
    @(negedge clk);
    stop4 = 1'b0;
    check("trig_wc", 32'(wc4), 1);
    t = -1;
    foreach (s4[i]) if (t < 0 && s4[i] == 4'hA) t = i;
    e4 = '0;
    if (t >= 0 && t + 3 < s4.size())
      for (int j = 0; j < 4; j++) e4 = e4 | (16'(s4[t + j]) << (4 * j));
    rq4 = 1'b1;
    @(negedge clk);
    rq4 = 1'b0;
    check("trig_rv", 32'(rv4), 1);
    check("trig_word", 32'(rd4), 32'(e4));
    check("trig_dcba", 32'(rd4), 32'hDCBA);

    // async reset mid-capture
    arm_d1(8'd0, 1'b1);
    feed1(40, 1'b0);
    check("ar_pre_wc", 32'(wc1), 2);
    #2;
    reset_n = 1'b0;
    #1;
    check("ar_busy", 32'(busy1), 0);
    check("ar_wc", 32'(wc1), 0);
    check("ar_rv", 32'(rv1), 0);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    arm_d1(8'd0, 1'b0);
    feed1(16, 1'b0);
    stop_d1();
    check("ar_new_wc", 32'(wc1), 1);
    check("ar_new_wrap", 32'(wrap1), 0);
    rq1 = 1'b1;
    @(negedge clk);
    rq1 = 1'b0;
    check("ar_new_word", 32'(rd1), 32'(exp_w[0]));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
